ring_freq_meter: RTL and testbench

Frequency meter that sits directly downstream of the ring-oscillator array. It takes the free-running ring outputs, selects one, counts its rising edges in a Gray-coded counter clocked by the ring itself, and measures that count over a fixed gate window of system-clock cycles. It delivers an edge count per gate, so each ring's period can be read against the board clock.

---
 rtl/ring_freq_meter.sv | 197 +++++++++++++++++++
 tb/tb_ring_freq_meter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_freq_meter.sv
// ring_freq_meter: counts rising edges of one selected ring oscillator over a
// fixed gate of 2^pGATE_LOG2 i_clk cycles and reports the count per gate.
//
// The selected ring clocks a Gray-coded counter. That counter is brought into
// the i_clk domain through a 2-flop synchronizer and converted back to binary
// as 'snap'. The result is the modular difference of two snaps taken at the
// start and end of the gate.
//
// Ports:
//   i_clk    system/reference clock
//   i_rst_n  asynchronous active-low reset (also clears the ring counter)
//   i_ring   raw ring oscillator outputs, asynchronous to i_clk
//   i_sel    ring index, latched on acceptance; out-of-range selects ring 0
//   i_start  measurement request, honoured only while idle
//   o_busy   high whenever a measurement is in progress
//   o_valid  one-cycle pulse when o_count is updated
//   o_count  ring rising edges counted during the last gate
//   o_ovf    implausible-sample flag (only with RING_METER_OVF_EN)
//
// Build option: define RING_METER_OVF_EN to add o_ovf and the per-cycle
// snapshot delta comparator.

module ring_freq_meter #(
  parameter int unsigned pRINGS     = 6,
  parameter int unsigned pCNT_W     = 16,
  parameter int unsigned pGATE_LOG2 = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [pRINGS-1:0] i_ring,
  input  logic [3:0]        i_sel,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_valid,
  output logic [pCNT_W-1:0] o_count
`ifdef RING_METER_OVF_EN
  ,
  output logic              o_ovf
`endif
);

  localparam int unsigned CNT_W  = pCNT_W;
  localparam int unsigned GATE_W = pGATE_LOG2;
  localparam int unsigned PH_W   = 3;
  localparam logic [PH_W-1:0] ARM_LAST = PH_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_DONE
  } state_t;

  state_t              state;
  logic [3:0]          sel_q;
  logic [PH_W-1:0]     phase;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    start_val;
  logic [CNT_W-1:0]    end_val;

  logic                ring_clk_c;
  logic [CNT_W-1:0]    ring_bin;
  logic [CNT_W-1:0]    ring_bin_inc_c;
  logic [CNT_W-1:0]    ring_gray;
  logic [CNT_W-1:0]    sync1;
  logic [CNT_W-1:0]    sync2;
  logic [CNT_W-1:0]    snap;

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = int'(CNT_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Ring mux; sel_q is already clamped to a valid index on acceptance.
  always_comb begin
    ring_clk_c = i_ring[0];
    for (int i = 0; i < int'(pRINGS); i++) begin
      if (sel_q == 4'(i)) ring_clk_c = i_ring[i];
    end
  end

  assign ring_bin_inc_c = ring_bin + CNT_W'(1);

  // Ring-domain counter; the Gray copy is what crosses into i_clk.
  always_ff @(posedge ring_clk_c or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ring_bin  <= '0;
      ring_gray <= '0;
    end else begin
      ring_bin  <= ring_bin_inc_c;
      ring_gray <= ring_bin_inc_c ^ (ring_bin_inc_c >> 1);
    end
  end

  // Two-flop synchronizer followed by a registered binary snapshot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      snap  <= '0;
    end else begin
      sync1 <= ring_gray;
      sync2 <= sync1;
      snap  <= gray2bin(sync2);
    end
  end

`ifdef RING_METER_OVF_EN
  localparam logic [CNT_W-1:0] OVF_LIM = CNT_W'(1) << (CNT_W - 2);

  logic [CNT_W-1:0] snap_prev;
  logic [CNT_W-1:0] snap_delta_c;
  logic             ovf_acc;

  assign snap_delta_c = snap - snap_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) snap_prev <= '0;
    else          snap_prev <= snap;
  end
`endif

  // Measurement sequencer: IDLE -> ARM (flush) -> GATE -> DONE (2 cycles).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      phase     <= '0;
      gate_cnt  <= '0;
      start_val <= '0;
      end_val   <= '0;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_count   <= '0;
`ifdef RING_METER_OVF_EN
      ovf_acc   <= 1'b0;
      o_ovf     <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_ARM;
            phase  <= '0;
            sel_q  <= (32'(i_sel) < pRINGS) ? i_sel : 4'd0;
            o_busy <= 1'b1;
`ifdef RING_METER_OVF_EN
            ovf_acc <= 1'b0;
            o_ovf   <= 1'b0;
`endif
          end
        end
        ST_ARM: begin
          if (phase == ARM_LAST) begin
            state     <= ST_GATE;
            start_val <= snap;
            gate_cnt  <= '0;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        ST_GATE: begin
          gate_cnt <= gate_cnt + GATE_W'(1);
`ifdef RING_METER_OVF_EN
          if (snap_delta_c > OVF_LIM) ovf_acc <= 1'b1;
`endif
          if (gate_cnt == '1) begin
            end_val <= snap;
            phase   <= '0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First cycle publishes the result, second cycle drops busy.
          if (phase == '0) begin
            o_count <= end_val - start_val;
            o_valid <= 1'b1;
            phase   <= PH_W'(1);
`ifdef RING_METER_OVF_EN
            o_ovf   <= ovf_acc;
`endif
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: free-running ring generators with adjustable
// half-periods, a reference model predicting edges per gate from the ring
// period, and latency / handshake checks around each measurement.

module tb_ring_freq_meter;

  localparam int unsigned RINGS     = 6;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned GATE_LOG2 = 8;
  localparam int unsigned GATE_N    = 1 << GATE_LOG2;
  localparam int unsigned CLK_T     = 1000;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  wire  [RINGS-1:0] ring;
  logic [3:0]       sel   = 4'd0;
  logic             start = 1'b0;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] count;
`ifdef RING_METER_OVF_EN
  logic             ovf;
  bit               ovf_last;
`endif

  int unsigned ring_half [RINGS];
  logic        man0 = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] last_cnt = '0;

  always #(CLK_T/2) clk = ~clk;

  // Ring toggles always fall on times == 3 (mod 10), never on a clock edge.
  for (genvar g = 0; g < RINGS; g++) begin : g_ring
    logic r = 1'b0;
    initial begin
      #(3 + 10*g);
      forever begin
        if (ring_half[g] == 0) #10;
        else begin
          #(ring_half[g]);
          r = ~r;
        end
      end
    end
    assign ring[g] = r ^ ((g == 0) ? man0 : 1'b0);
  end

  ring_freq_meter #(
    .pRINGS(RINGS),
    .pCNT_W(CNT_W),
    .pGATE_LOG2(GATE_LOG2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_ring(ring),
    .i_sel(sel),
    .i_start(start),
    .o_busy(busy),
    .o_valid(valid),
    .o_count(count)
`ifdef RING_METER_OVF_EN
    ,
    .o_ovf(ovf)
`endif
  );

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Reference: a gate of GATE_N*CLK_T time units holds gate/period ring edges.
  function automatic longint exp_edges(input logic [3:0] s);
    int unsigned idx;
    longint      per;
    idx = (32'(s) < RINGS) ? 32'(s) : 0;
    per = 2 * longint'(ring_half[idx]);
    return (longint'(GATE_N) * CLK_T + per / 2) / per;
  endfunction

  task automatic settle();
    repeat (15) @(negedge clk);
  endtask

  task automatic kick(input logic [3:0] s);
    @(negedge clk);
    sel   = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sel   = 4'($urandom);
    check("busy_after_accept", busy, 1, 0);
  endtask

  // Runs from the cycle after acceptance to the end of the measurement.
  // inj: cycle at which to pulse i_start with i_sel=0 (must be ignored).
  // hold: keep i_start high after o_valid to check the back-to-back restart.
  task automatic wait_done(input int inj, input bit hold, input logic [3:0] hold_sel,
                           output logic [CNT_W-1:0] cnt);
    int vc     = 0;
    int nvalid = 0;
    bit got    = 1'b0;
    cnt = '0;
    for (int c = 1; c <= int'(GATE_N) + 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 10) check("count_hold", count, last_cnt, 0);
      if (valid) begin
        nvalid++;
        if (!got) begin
          got = 1'b1;
          vc  = c;
          cnt = count;
`ifdef RING_METER_OVF_EN
          ovf_last = ovf;
`endif
        end
      end
      start = (c == inj) || (hold && got);
      if (c == inj) sel = 4'd0;
      else if (hold && got) sel = hold_sel;
      else sel = 4'($urandom);
      if (got && c == vc + 1) begin
        check("busy_fall", busy, 0, 0);
        if (!hold) break;
      end
      if (got && c == vc + 2) begin
        check("busy_restart", busy, 1, 0);
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    check("valid_seen", got, 1, 0);
    check("valid_pulses", nvalid, 1, 0);
    if (got) begin
      check("valid_latency", vc, 6 + GATE_N, 0);
      last_cnt = cnt;
    end
  endtask

  initial begin
    #(50_000_000);
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] cnt;
    int               seen;
    logic [3:0]       s;
    int               inj;

    for (int i = 0; i < RINGS; i++) ring_half[i] = 10 * $urandom_range(60, 600);

    // Reset held with rings running and i_start wiggling.
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      seen += int'(valid);
    end
    check("rst_no_valid", seen, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_valid", valid, 0, 0);
    check("rst_count", count, 0, 0);
`ifdef RING_METER_OVF_EN
    check("rst_ovf", ovf, 0, 0);
`endif
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic: ring 0, 40 ns period, gate 256 x 10 ns -> 64 edges.
    ring_half[0] = 2000;
    settle();
    kick(4'd0);
    wait_done(-1, 1'b0, 4'd0, cnt);
    check("basic_count", cnt, 64, 1);

    // Ring 3 at 20 ns; i_start with i_sel=0 during GATE must be ignored.
    ring_half[3] = 1000;
    settle();
    kick(4'd3);
    wait_done(100, 1'b0, 4'd0, cnt);
    check("sel3_count", cnt, 128, 1);

    // Out-of-range index falls back to ring 0; i_start held for a restart.
    kick(4'd11);
    wait_done(-1, 1'b1, 4'd11, cnt);
    check("sel_oor_count", cnt, 64, 1);
    wait_done(-1, 1'b0, 4'd0, cnt);
    check("b2b_count", cnt, 64, 1);

    // Randomized periods, selects and busy-time start pulses.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < RINGS; i++) ring_half[i] = 10 * $urandom_range(60, 600);
      settle();
      s   = 4'($urandom_range(0, 15));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, GATE_N)) : -1;
      kick(s);
      wait_done(inj, 1'b0, 4'd0, cnt);
      check("rand_count", cnt, exp_edges(s), 1);
    end

    // Abort mid-gate: outputs clear immediately, no o_valid afterwards.
    ring_half[0] = 2000;
    settle();
    kick(4'd0);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0, 0);
    check("abort_count", count, 0, 0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    last_cnt = '0;
    seen     = 0;
    for (int i = 0; i < int'(GATE_N) + 20; i++) begin
      @(negedge clk);
      seen += int'(valid);
    end
    check("abort_no_valid", seen, 0, 0);
    check("abort_idle", busy, 0, 0);
    kick(4'd0);
    wait_done(-1, 1'b0, 4'd0, cnt);
    check("after_abort_count", cnt, 64, 1);

    // Wrap: park the 8-bit counter near 0xFE, then measure across the wrap.
    for (int i = 0; i < RINGS; i++) ring_half[i] = 0;
    settle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    last_cnt = '0;
    for (int i = 0; i < 252; i++) begin
      #7 man0 = 1'b1;
      #10 man0 = 1'b0;
      #3;
    end
    ring_half[0] = 2000;
    kick(4'd0);
    wait_done(-1, 1'b0, 4'd0, cnt);
    check("wrap_count", cnt, 64, 1);

`ifdef RING_METER_OVF_EN
    // A ring far faster than the snapshot can follow must raise o_ovf.
    ring_half[0] = 5;
    settle();
    kick(4'd0);
    wait_done(-1, 1'b0, 4'd0, cnt);
    check("ovf_set", ovf_last, 1, 0);
    ring_half[0] = 2000;
    settle();
    kick(4'd0);
    wait_done(-1, 1'b0, 4'd0, cnt);
    check("ovf_clear", ovf_last, 0, 0);
    check("ovf_follow_count", cnt, 64, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
